fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 193 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit -- instruction-fetch stage, directly upstream of the decoder.
//
// Holds the PC, fetches one instruction word at a time from instruction memory
// over a req/ack handshake, presents it to decode over valid/ready, and on
// consume steps the PC to the target selected by the decoder (sequential,
// jump or conditional branch). Peak throughput is one instruction per two
// cycles: one cycle in REQ with a zero-wait ack, one cycle in VALID.
//
// Optional feature macro: FETCH_ALIGN_CHK_EN
//   defined   : a misaligned PC in REQ suppresses the request, sets fault and
//               parks the unit in HALTED until reset.
//   undefined : no check; fault is constant 0 and pc[1:0] goes to imem_addr.
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   imem_req    out  fetch request, held until acked
//   imem_addr   out  word address (= pc), stable while imem_req
//   imem_ack    in   memory accepts and returns imem_rdata this cycle
//   imem_rdata  in   instruction word, valid with imem_ack
//   inst        out  captured instruction for the decoder
//   inst_valid  out  inst holds a valid instruction
//   inst_ready  in   decoder consumes inst this cycle
//   pc          out  address of inst
//   pc_plus4    out  pc + 4 (link value source)
//   pc_src      in   PC source for the consumed instruction
//   jaddr       in   jump field of the consumed instruction
//   imm         in   branch offset of the consumed instruction
//   br_taken    in   branch condition for the consumed instruction
//   halt        in   stop fetching after the consumed instruction
//   halted      out  fetch permanently stopped (until reset)
//   fault       out  misaligned PC detected (feature build only)
// -----------------------------------------------------------------------------

`ifndef W_CPU
`define W_CPU 32
`endif
`ifndef W_PC_SRC
`define W_PC_SRC 2
`endif
`ifndef W_JADDR
`define W_JADDR 26
`endif
`ifndef W_IMM
`define W_IMM 16
`endif
`ifndef PC_SRC_NEXT
`define PC_SRC_NEXT 2'd0
`endif
`ifndef PC_SRC_JUMP
`define PC_SRC_JUMP 2'd1
`endif
`ifndef PC_SRC_BRCH
`define PC_SRC_BRCH 2'd2
`endif

// state   | meaning
// --------+---------------------------------------------------------------
// REQ     | request outstanding at pc, waiting for imem_ack
// VALID   | inst/pc presented to decode, waiting for inst_ready
// HALTED  | fetch stopped (halt consumed or misaligned pc); only rst exits

module fetch_unit #(
    parameter int              W_PC     = 32,
    parameter logic [W_PC-1:0] RESET_PC = 32'h0040_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req,
    output logic [W_PC-1:0]      imem_addr,
    input  logic                 imem_ack,
    input  logic [`W_CPU-1:0]    imem_rdata,
    output logic [`W_CPU-1:0]    inst,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [W_PC-1:0]      pc,
    output logic [W_PC-1:0]      pc_plus4,
    input  logic [`W_PC_SRC-1:0] pc_src,
    input  logic [`W_JADDR-1:0]  jaddr,
    input  logic [`W_IMM-1:0]    imm,
    input  logic                 br_taken,
    input  logic                 halt,
    output logic                 halted,
    output logic                 fault
);

    typedef enum logic [1:0] {
        ST_REQ    = 2'd0,
        ST_VALID  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [W_PC-1:0]     pc_q, pc_d;
    logic [`W_CPU-1:0]   inst_q, inst_d;
    logic                inst_valid_q, inst_valid_d;
    logic                fault_q, fault_d;

    logic                align_err;
    logic                consume;
    logic [W_PC-1:0]     pc_plus4_w;
    logic [W_PC-1:0]     br_target;
    logic [W_PC-1:0]     j_target;
    logic [W_PC-1:0]     next_pc;

`ifdef FETCH_ALIGN_CHK_EN
    // Branch/jump targets are word aligned by construction, so only a
    // misaligned RESET_PC can trip this.
    assign align_err = (pc_q[1:0] != 2'b00);
`else
    assign align_err = 1'b0;
`endif

    assign consume    = inst_valid_q & inst_ready;
    assign pc_plus4_w = pc_q + W_PC'(4);

    // Word-scaled, sign-extended branch offset relative to pc+4; sums wrap.
    assign br_target  = pc_plus4_w + {{(W_PC-18){imm[15]}}, imm, 2'b00};
    // Jump stays in the 256 MB region of the delay-slot address.
    assign j_target   = {pc_plus4_w[W_PC-1:W_PC-4], jaddr, 2'b00};

    always_comb begin
        next_pc = pc_plus4_w;
        case (pc_src)
            `PC_SRC_JUMP: next_pc = j_target;
            `PC_SRC_BRCH: next_pc = br_taken ? br_target : pc_plus4_w;
            default:      next_pc = pc_plus4_w;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        fault_d      = fault_q;
        case (state_q)
            ST_REQ: begin
                if (align_err) begin
                    fault_d = 1'b1;
                    state_d = ST_HALTED;
                end else if (imem_ack) begin
                    inst_d       = imem_rdata;
                    inst_valid_d = 1'b1;
                    state_d      = ST_VALID;
                end
            end
            ST_VALID: begin
                if (consume) begin
                    inst_valid_d = 1'b0;
                    pc_d         = next_pc;
                    state_d      = halt ? ST_HALTED : ST_REQ;
                end
            end
            ST_HALTED: begin
                inst_valid_d = 1'b0;
            end
            default: begin
                inst_valid_d = 1'b0;
                state_d      = ST_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_REQ;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            fault_q      <= fault_d;
        end
    end

    // All outputs decode registered state only; nothing flows through from
    // the handshake inputs in the same cycle.
    assign imem_req   = (state_q == ST_REQ) & ~align_err;
    assign imem_addr  = pc_q;
    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign pc         = pc_q;
    assign pc_plus4   = pc_plus4_w;
    assign halted     = (state_q == ST_HALTED);
    assign fault      = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [1:0] NX = 2'd0;
    localparam logic [1:0] JP = 2'd1;
    localparam logic [1:0] BR = 2'd2;
    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [1:0]  pc_src;
    logic [25:0] jaddr;
    logic [15:0] imm;
    logic        br_taken;
    logic        halt;
    logic        halted;
    logic        fault;

    // second instance with a misaligned reset PC
    logic        req2;
    logic [31:0] addr2;
    logic [31:0] inst2;
    logic        valid2;
    logic [31:0] pc2;
    logic [31:0] pc2_plus4;
    logic        halted2;
    logic        fault2;
    logic        ack2;

    int total = 0;
    int bad   = 0;

    fetch_unit #(.W_PC(32), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .pc(pc), .pc_plus4(pc_plus4),
        .pc_src(pc_src), .jaddr(jaddr), .imm(imm), .br_taken(br_taken),
        .halt(halt), .halted(halted), .fault(fault)
    );

    fetch_unit #(.W_PC(32), .RESET_PC(32'h0040_0002)) dut2 (
        .clk(clk), .rst(rst),
        .imem_req(req2), .imem_addr(addr2),
        .imem_ack(ack2), .imem_rdata(32'h1234_5678),
        .inst(inst2), .inst_valid(valid2), .inst_ready(1'b1),
        .pc(pc2), .pc_plus4(pc2_plus4),
        .pc_src(NX), .jaddr(26'd0), .imm(16'd0), .br_taken(1'b0),
        .halt(1'b0), .halted(halted2), .fault(fault2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic [1:0]  src;
        logic [25:0] jaddr;
        logic [15:0] imm;
        logic        br;
        logic        halt;
        logic        e_req;
        logic        e_valid;
        logic        e_halted;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    vec_t vq[$];

    task automatic addv(input logic a, input logic [31:0] rd, input logic rdy,
                        input logic [1:0] s, input logic [25:0] ja, input logic [15:0] im,
                        input logic b, input logic h, input logic er, input logic ev,
                        input logic eh, input logic [31:0] ep, input logic [31:0] ei);
        vec_t v;
        v.ack = a; v.rdata = rd; v.ready = rdy; v.src = s; v.jaddr = ja; v.imm = im;
        v.br = b; v.halt = h; v.e_req = er; v.e_valid = ev; v.e_halted = eh;
        v.e_pc = ep; v.e_inst = ei;
        vq.push_back(v);
    endtask

    task automatic idle_inputs();
        imem_ack = 1'b0; imem_rdata = '0; inst_ready = 1'b0; pc_src = NX;
        jaddr = '0; imm = '0; br_taken = 1'b0; halt = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // reference model state: transaction level, not cycle-state encoded
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    bit          m_have;
    bit          m_halt;

    function automatic logic [31:0] ref_target(input logic [31:0] p, input logic [1:0] s,
                                               input logic [25:0] ja, input logic [15:0] im,
                                               input logic b);
        logic [31:0] seq;
        seq = p + 32'd4;
        if (s == JP)
            return (seq & 32'hF000_0000) | ({6'd0, ja} * 32'd4);
        if (s == BR && b)
            return seq + 32'(int'($signed(im)) * 4);
        return seq;
    endfunction

    initial begin
        idle_inputs();
        ack2 = 1'b1;
        rst  = 1'b1;

        // ---- reset state (async, before any clock edge) ----
        #2;
        chk("rst_pc", pc, RPC);
        chk("rst_inst", inst, 32'd0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_pc2", pc2, 32'h0040_0002);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ---- misaligned reset PC instance ----
`ifdef FETCH_ALIGN_CHK_EN
        chk("mis_req", {31'd0, req2}, 32'd0);
        @(posedge clk);
        #1;
        chk("mis_fault", {31'd0, fault2}, 32'd1);
        chk("mis_halted", {31'd0, halted2}, 32'd1);
        chk("mis_req_after", {31'd0, req2}, 32'd0);
`else
        chk("mis_req", {31'd0, req2}, 32'd1);
        chk("mis_addr", addr2, 32'h0040_0002);
        @(posedge clk);
        #1;
        chk("mis_fault", {31'd0, fault2}, 32'd0);
        chk("mis_halted", {31'd0, halted2}, 32'd0);
`endif
        do_reset();

        // ---- directed table: ack, rdata, ready, src, jaddr, imm, br, halt |
        //      exp req, valid, halted, pc, inst ----
        addv(0, 0,            0, NX, 0, 0, 0, 0,  1, 0, 0, 32'h0040_0000, 0);
        addv(0, 0,            0, NX, 0, 0, 0, 0,  1, 0, 0, 32'h0040_0000, 0);
        addv(1, 32'h2008_0005,0, NX, 0, 0, 0, 0,  1, 0, 0, 32'h0040_0000, 0);
        addv(0, 0,            0, NX, 0, 0, 0, 0,  0, 1, 0, 32'h0040_0000, 32'h2008_0005);
        addv(0, 0,            0, NX, 0, 0, 0, 0,  0, 1, 0, 32'h0040_0000, 32'h2008_0005);
        addv(0, 0,            0, NX, 0, 0, 0, 0,  0, 1, 0, 32'h0040_0000, 32'h2008_0005);
        addv(0, 0,            1, NX, 0, 0, 0, 0,  0, 1, 0, 32'h0040_0000, 32'h2008_0005);
        addv(1, 32'h1,        0, NX, 0, 0, 0, 0,  1, 0, 0, 32'h0040_0004, 0);
        addv(0, 0,            1, NX, 0, 0, 0, 0,  0, 1, 0, 32'h0040_0004, 32'h1);
        addv(1, 32'h2,        0, NX, 0, 0, 0, 0,  1, 0, 0, 32'h0040_0008, 0);
        addv(0, 0,            1, NX, 0, 0, 0, 0,  0, 1, 0, 32'h0040_0008, 32'h2);
        addv(1, 32'h3,        0, NX, 0, 0, 0, 0,  1, 0, 0, 32'h0040_000C, 0);
        addv(0, 0,            1, NX, 0, 0, 0, 0,  0, 1, 0, 32'h0040_000C, 32'h3);
        addv(1, 32'h1000_FFFE,0, NX, 0, 0, 0, 0,  1, 0, 0, 32'h0040_0010, 0);
        addv(0, 0,            1, BR, 0, 16'hFFFE, 1, 0,  0, 1, 0, 32'h0040_0010, 32'h1000_FFFE);
        addv(1, 32'h4,        0, NX, 0, 0, 0, 0,  1, 0, 0, 32'h0040_000C, 0);
        addv(0, 0,            1, NX, 0, 0, 0, 0,  0, 1, 0, 32'h0040_000C, 32'h4);
        addv(1, 32'h5,        0, NX, 0, 0, 0, 0,  1, 0, 0, 32'h0040_0010, 0);
        addv(0, 0,            1, BR, 0, 16'hFFFE, 0, 0,  0, 1, 0, 32'h0040_0010, 32'h5);
        addv(1, 32'h6,        0, NX, 0, 0, 0, 0,  1, 0, 0, 32'h0040_0014, 0);
        addv(0, 0,            1, JP, 26'h010_0008, 0, 0, 0,  0, 1, 0, 32'h0040_0014, 32'h6);
        addv(1, 32'h0810_0008,0, NX, 0, 0, 0, 0,  1, 0, 0, 32'h0040_0020, 0);
        addv(0, 0,            1, JP, 26'h010_0008, 0, 0, 0,  0, 1, 0, 32'h0040_0020, 32'h0810_0008);
        addv(0, 0,            0, NX, 0, 0, 0, 0,  1, 0, 0, 32'h0040_0020, 0);
        addv(1, 32'h7,        0, NX, 0, 0, 0, 0,  1, 0, 0, 32'h0040_0020, 0);
        addv(0, 0,            1, JP, 26'h0, 0, 0, 0,  0, 1, 0, 32'h0040_0020, 32'h7);
        addv(1, 32'h8,        0, NX, 0, 0, 0, 0,  1, 0, 0, 32'h0000_0000, 0);
        addv(0, 0,            1, BR, 0, 16'hFFFE, 1, 0,  0, 1, 0, 32'h0000_0000, 32'h8);
        addv(1, 32'h9,        0, NX, 0, 0, 0, 0,  1, 0, 0, 32'hFFFF_FFFC, 0);
        addv(0, 0,            1, 2'd3, 0, 0, 1, 0,  0, 1, 0, 32'hFFFF_FFFC, 32'h9);
        addv(1, 32'hA,        0, NX, 0, 0, 0, 0,  1, 0, 0, 32'h0000_0000, 0);
        addv(0, 0,            1, NX, 0, 0, 0, 1,  0, 1, 0, 32'h0000_0000, 32'hA);
        for (int i = 0; i < 20; i++)
            addv(1, 32'hDEAD_0000 + i, 1, JP, 26'h3FF_FFFF, 16'h1234, 1, 0,  0, 0, 1, 32'h0000_0004, 0);

        foreach (vq[i]) begin
            imem_ack   = vq[i].ack;
            imem_rdata = vq[i].rdata;
            inst_ready = vq[i].ready;
            pc_src     = vq[i].src;
            jaddr      = vq[i].jaddr;
            imm        = vq[i].imm;
            br_taken   = vq[i].br;
            halt       = vq[i].halt;
            chk($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, vq[i].e_req});
            chk($sformatf("v%0d_valid", i), {31'd0, inst_valid}, {31'd0, vq[i].e_valid});
            chk($sformatf("v%0d_halted", i), {31'd0, halted}, {31'd0, vq[i].e_halted});
            chk($sformatf("v%0d_pc", i), pc, vq[i].e_pc);
            chk($sformatf("v%0d_pc4", i), pc_plus4, vq[i].e_pc + 32'd4);
            if (vq[i].e_req)
                chk($sformatf("v%0d_addr", i), imem_addr, vq[i].e_pc);
            if (vq[i].e_valid)
                chk($sformatf("v%0d_inst", i), inst, vq[i].e_inst);
            @(posedge clk);
            #1;
        end

        // ---- async reset mid-REQ with an ack arriving during reset ----
        do_reset();
        imem_ack = 1'b1; imem_rdata = 32'h0000_00AA;
        @(posedge clk);
        #1;
        imem_ack = 1'b0; inst_ready = 1'b1; pc_src = NX;
        @(posedge clk);
        #1;
        inst_ready = 1'b0;
        chk("mid_req", {31'd0, imem_req}, 32'd1);
        chk("mid_addr", imem_addr, 32'h0040_0004);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_pc", pc, RPC);
        chk("mid_rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("mid_rst_inst", inst, 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'h0000_00BB;
        @(posedge clk);
        #1;
        chk("rst_ack_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_ack_inst", inst, 32'd0);
        imem_ack = 1'b0;
        rst = 1'b0;
        chk("post_rst_req", {31'd0, imem_req}, 32'd1);
        chk("post_rst_addr", imem_addr, RPC);
        @(posedge clk);
        #1;
        chk("post_rst_valid", {31'd0, inst_valid}, 32'd0);

        // ---- randomized run against the reference model ----
        do_reset();
        m_pc = RPC; m_inst = '0; m_have = 0; m_halt = 0;
        begin
            int halt_cycles = 0;
            for (int cyc = 0; cyc < 4000; cyc++) begin
                imem_ack   = ($urandom_range(0, 2) != 0);
                imem_rdata = $urandom;
                inst_ready = ($urandom_range(0, 2) != 0);
                pc_src     = 2'($urandom_range(0, 3));
                jaddr      = 26'($urandom);
                imm        = 16'($urandom);
                br_taken   = 1'($urandom);
                halt       = ($urandom_range(0, 40) == 0);

                chk("rnd_req", {31'd0, imem_req}, {31'd0, (!m_have && !m_halt)});
                chk("rnd_valid", {31'd0, inst_valid}, {31'd0, m_have});
                chk("rnd_halted", {31'd0, halted}, {31'd0, m_halt});
                chk("rnd_pc", pc, m_pc);
                chk("rnd_pc4", pc_plus4, m_pc + 32'd4);
                if (!m_have && !m_halt)
                    chk("rnd_addr", imem_addr, m_pc);
                if (m_have)
                    chk("rnd_inst", inst, m_inst);

                if (!m_have && !m_halt) begin
                    if (imem_ack) begin
                        m_have = 1;
                        m_inst = imem_rdata;
                    end
                end else if (m_have && inst_ready) begin
                    m_pc   = ref_target(m_pc, pc_src, jaddr, imm, br_taken);
                    m_have = 0;
                    if (halt) m_halt = 1;
                end

                @(posedge clk);
                #1;

                if (m_halt) halt_cycles++;
                if (halt_cycles > 4) begin
                    do_reset();
                    m_pc = RPC; m_inst = '0; m_have = 0; m_halt = 0;
                    halt_cycles = 0;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
